mux_nto1_reg: RTL and testbench

Parametrised, registered N-to-1 multiplexer with valid/ready handshakes on every input channel and on the output. It is the next generation of the combinational 2-to-1 mux in the predictor datapath. It sits between multiple producers (PC sources, predictor table read ports) and a single consumer. It selects one channel per cycle, either by an explicit select input or, optionally, by round-robin arbitration, and holds the result in a one-entry output register.

---
 rtl/mux_nto1_reg.sv | 90 +++++++++
 tb/tb_mux_nto1_reg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 valid/ready mux, explicit select or (with MUXN_RR_EN) round-robin.
// Latency: one cycle from input transfer to out_data; one word per cycle sustained.
// Backpressure: output stall freezes the register and drops every in_ready.
module mux_nto1_reg #(
   parameter int  WIDTH    = 16,
   parameter int  CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          sel,
`ifdef MUXN_RR_EN
   input  logic                      rr_mode,
`endif
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic                can_accept;
   logic                sel_ok;
   logic                gnt_en;
   logic [SEL_W-1:0]    gnt_idx;
   logic [CHANNELS-1:0] rdy_vec;
   logic                xfer;

   assign can_accept = !out_valid || out_ready;
   assign sel_ok     = ({1'b0, sel} < (SEL_W+1)'(CHANNELS));

`ifdef MUXN_RR_EN
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] rr_idx;
   logic             rr_found;

   // Scan from the far end so the last hit is the nearest channel after ptr.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int i = CHANNELS; i >= 1; i--) begin
         if (in_valid[(int'(ptr) + i) % CHANNELS]) begin
            rr_found = 1'b1;
            rr_idx   = SEL_W'((int'(ptr) + i) % CHANNELS);
         end
      end
   end

   always_comb begin
      gnt_idx = sel;
      gnt_en  = sel_ok;
      if (rr_mode) begin
         gnt_idx = rr_idx;
         gnt_en  = rr_found;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= SEL_W'(CHANNELS - 1);
      end else if (rr_mode && xfer) begin
         ptr <= gnt_idx;
      end
   end
`else
   assign gnt_idx = sel;
   assign gnt_en  = sel_ok;
`endif

   assign rdy_vec  = gnt_en ? ({{(CHANNELS-1){1'b0}}, 1'b1} << gnt_idx) : '0;
   assign in_ready = (rst_n && can_accept) ? rdy_vec : '0;
   assign xfer     = |(in_ready & in_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
         out_chan  <= gnt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Bench for mux_nto1_reg: directed scenarios plus random traffic against a behavioural model.
// Round-robin scenarios run only when MUXN_RR_EN is defined for the build.
module tb_mux_nto1_reg;

   localparam int WIDTH = 16;
   localparam int CH    = 4;
   localparam int SW    = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [CH*WIDTH-1:0] in_data;
   logic [CH-1:0]     in_valid;
   logic [CH-1:0]     in_ready;
   logic [SW-1:0]     sel;
   logic              rr_mode;
   logic [WIDTH-1:0]  out_data;
   logic [SW-1:0]     out_chan;
   logic              out_valid;
   logic              out_ready;

   int vectors     = 0;
   int miscompares = 0;

   // model state
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   int               m_chan;
   int               m_ptr;

   always #5 clk = ~clk;

   mux_nto1_reg #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .sel(sel),
`ifdef MUXN_RR_EN
      .rr_mode(rr_mode),
`endif
      .out_data(out_data),
      .out_chan(out_chan),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_ptr   = CH - 1;
   endtask

   function automatic bit rr_active();
`ifdef MUXN_RR_EN
      return rr_mode;
`else
      return 1'b0;
`endif
   endfunction

   // Which channel the block offers to take this cycle (-1 = none).
   function automatic int offered();
      if (!rst_n || (m_valid && !out_ready)) return -1;
      if (rr_active()) begin
         for (int k = 1; k <= CH; k++) begin
            if (in_valid[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
         end
         return -1;
      end
      return (int'(sel) < CH) ? int'(sel) : -1;
   endfunction

   // Check the current cycle against the model, advance the model, cross one clock.
   task automatic step();
      int g;
      logic [CH-1:0] exp_rdy;
      #1;
      g = offered();
      exp_rdy = (g >= 0) ? CH'(1 << g) : '0;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_chan", 32'(out_chan), 32'(m_chan));
      if (!rst_n) begin
         model_reset();
      end else if (g >= 0 && in_valid[g]) begin
         m_valid = 1'b1;
         m_data  = in_data[g*WIDTH +: WIDTH];
         m_chan  = g;
         if (rr_active()) m_ptr = g;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ch(input int c, input logic [WIDTH-1:0] d);
      in_data[c*WIDTH +: WIDTH] = d;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = '1;
      sel       = 2'd0;
      rr_mode   = 1'b0;
      out_ready = 1'b1;
      model_reset();
      @(negedge clk);

      // reset with all channels requesting
      step();
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      rst_n = 1'b1;

      // explicit select
      sel = 2'd2; in_valid = 4'b0100; set_ch(2, 16'hA5A5);
      #1 chk("sel_in_ready", 32'(in_ready), 32'h4);
      step();
      chk("sel_out_data", 32'(out_data), 32'hA5A5);
      chk("sel_out_chan", 32'(out_chan), 32'd2);

      // backpressure
      sel = 2'd1; in_valid = 4'b0010; set_ch(1, 16'h5555);
      step();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sel = SW'(k + 2);
         in_valid = '1;
         set_ch(k + 2, 16'(16'h1234 * (k + 1)));
         set_ch(1, 16'hDEAD);
         step();
         chk("bp_hold_data", 32'(out_data), 32'h5555);
         chk("bp_hold_chan", 32'(out_chan), 32'd1);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_rdy", 32'(in_ready), 32'h1 << sel);
      step();

`ifdef MUXN_RR_EN
      // round-robin fairness, no bubbles
      rr_mode = 1'b1; in_valid = '1;
      for (int c = 0; c < CH; c++) set_ch(c, 16'(16'h1111 * c));
      for (int k = 0; k < 8; k++) begin
         step();
         chk("rr_fair_chan", 32'(out_chan), 32'(k % CH));
         chk("rr_fair_data", 32'(out_data), 32'(16'h1111 * (k % CH)));
         chk("rr_fair_valid", 32'(out_valid), 32'h1);
      end
      // skip and wrap from ptr=3
      in_valid = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rr_skip_chan", 32'(out_chan), (k % 2 == 0) ? 32'd0 : 32'd3);
      end
      in_valid = '1;
`endif

      // asynchronous reset between edges, mid-stream
      sel = 2'd0; in_valid = '1;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'h0);
      chk("arst_out_data", 32'(out_data), 32'h0);
      chk("arst_out_chan", 32'(out_chan), 32'h0);
      chk("arst_in_ready", 32'(in_ready), 32'h0);
      model_reset();
      @(negedge clk);
      step();
      rst_n = 1'b1;
      sel = 2'd3;
      step();
      chk("post_rst_chan", 32'(out_chan), rr_active() ? 32'd0 : 32'd3);
      chk("post_rst_valid", 32'(out_valid), 32'h1);

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         in_valid  = CH'($urandom);
         sel       = SW'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom, $urandom};
`ifdef MUXN_RR_EN
         if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
`endif
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
